// File: rtl/openmips_min_sopc.sv
// rtl/openmips_min_sopc.sv - single-cycle MIPS-subset core with fixed ROM, GPR file and seven-segment debug display
module openmips_min_sopc (
    input  logic       clk_100mhz,
    input  logic [7:0] sw,
    input  logic [4:0] btn,
    output logic [7:0] seg,
    output logic [3:0] an,
    output logic [7:0] led
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;

    logic [31:0] r_pc;
    logic [31:0] r_gpr [32];
    logic [17:0] r_refresh;

    logic        w_rst;
    logic        w_pause;
    logic        w_unused;
    logic [31:0] w_instr;
    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_shamt;
    logic [5:0]  w_funct;
    logic [15:0] w_imm;
    logic [25:0] w_index;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic [31:0] w_imm_sext;
    logic [31:0] w_imm_zext;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_target;
    logic [31:0] w_next_pc;
    logic        w_we;
    logic [4:0]  w_waddr;
    logic [31:0] w_wdata;
    logic [31:0] w_sel_val;
    logic [1:0]  w_digit;
    logic [3:0]  w_nibble;

    assign w_rst    = sw[7];
    assign w_pause  = btn[0];
    assign w_unused = &{1'b0, sw[6:5], btn[4:1]};

    // Fixed program; any word beyond the listed ones decodes as sll $0,$0,0.
    always_comb begin
        w_instr = 32'h0000_0000;
        case (r_pc[5:2])
            4'd0:    w_instr = 32'h3401_1100;
            4'd1:    w_instr = 32'h3402_0020;
            4'd2:    w_instr = 32'h0022_1821;
            4'd3:    w_instr = 32'h3464_0044;
            4'd4:    w_instr = 32'h24A5_0001;
            4'd5:    w_instr = 32'h0800_0004;
            default: w_instr = 32'h0000_0000;
        endcase
    end

    assign w_op    = w_instr[31:26];
    assign w_rs    = w_instr[25:21];
    assign w_rt    = w_instr[20:16];
    assign w_rd    = w_instr[15:11];
    assign w_shamt = w_instr[10:6];
    assign w_funct = w_instr[5:0];
    assign w_imm   = w_instr[15:0];
    assign w_index = w_instr[25:0];

    assign w_rs_val    = (w_rs == 5'd0) ? 32'h0 : r_gpr[w_rs];
    assign w_rt_val    = (w_rt == 5'd0) ? 32'h0 : r_gpr[w_rt];
    assign w_imm_sext  = {{16{w_imm[15]}}, w_imm};
    assign w_imm_zext  = {16'h0000, w_imm};
    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_br_target = w_pc_plus4 + {w_imm_sext[29:0], 2'b00};

    always_comb begin
        w_we      = 1'b0;
        w_waddr   = w_rt;
        w_wdata   = 32'h0;
        w_next_pc = w_pc_plus4;
        case (w_op)
            OP_SPECIAL: begin
                w_waddr = w_rd;
                w_we    = 1'b1;
                case (w_funct)
                    FN_SLL:  w_wdata = w_rt_val << w_shamt;
                    FN_SRL:  w_wdata = w_rt_val >> w_shamt;
                    FN_ADDU: w_wdata = w_rs_val + w_rt_val;
                    FN_SUBU: w_wdata = w_rs_val - w_rt_val;
                    FN_AND:  w_wdata = w_rs_val & w_rt_val;
                    FN_OR:   w_wdata = w_rs_val | w_rt_val;
                    FN_XOR:  w_wdata = w_rs_val ^ w_rt_val;
                    FN_NOR:  w_wdata = ~(w_rs_val | w_rt_val);
                    default: w_we    = 1'b0;
                endcase
            end
            OP_ADDIU: begin
                w_we    = 1'b1;
                w_wdata = w_rs_val + w_imm_sext;
            end
            OP_ANDI: begin
                w_we    = 1'b1;
                w_wdata = w_rs_val & w_imm_zext;
            end
            OP_ORI: begin
                w_we    = 1'b1;
                w_wdata = w_rs_val | w_imm_zext;
            end
            OP_XORI: begin
                w_we    = 1'b1;
                w_wdata = w_rs_val ^ w_imm_zext;
            end
            OP_LUI: begin
                w_we    = 1'b1;
                w_wdata = {w_imm, 16'h0000};
            end
            OP_BEQ: begin
                if (w_rs_val == w_rt_val) w_next_pc = w_br_target;
            end
            OP_BNE: begin
                if (w_rs_val != w_rt_val) w_next_pc = w_br_target;
            end
            OP_J: begin
                w_next_pc = {r_pc[31:28], w_index, 2'b00};
            end
            default: ;
        endcase
    end

    // Reset wins over pause; the display refresh counter ignores pause.
    always_ff @(posedge clk_100mhz) begin
        if (w_rst) begin
            r_pc      <= 32'h0;
            r_refresh <= 18'h0;
            for (int i = 0; i < 32; i++) begin
                r_gpr[i] <= 32'h0;
            end
        end else begin
            r_refresh <= r_refresh + 18'd1;
            if (!w_pause) begin
                r_pc <= w_next_pc;
                if (w_we && (w_waddr != 5'd0)) begin
                    r_gpr[w_waddr] <= w_wdata;
                end
            end
        end
    end

    assign w_sel_val = r_gpr[sw[4:0]];
    assign led       = w_sel_val[7:0];
    assign w_digit   = r_refresh[17:16];
    assign an        = ~(4'b0001 << w_digit);
    assign w_nibble  = w_sel_val[{w_digit, 2'b00} +: 4];

    always_comb begin
        seg = 8'hFF;
        case (w_nibble)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_openmips_min_sopc.sv
// tb/tb_openmips_min_sopc.sv - scoreboard bench for openmips_min_sopc
module tb_openmips_min_sopc;

    logic       clk = 1'b0;
    logic [7:0] sw;
    logic [4:0] btn;
    logic [7:0] seg;
    logic [3:0] an;
    logic [7:0] led;

    always #5 clk = ~clk;

    openmips_min_sopc dut (
        .clk_100mhz (clk),
        .sw         (sw),
        .btn        (btn),
        .seg        (seg),
        .an         (an),
        .led        (led)
    );

    typedef struct {
        logic [7:0] led;
        bit         chk_disp;
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    exp_t  q[$];
    string qn[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_exec   = 0;

    // Register contents after n executed edges of the fixed program.
    function automatic logic [31:0] model_gpr(int sel, int n);
        case (sel)
            1:       return (n >= 1) ? 32'h0000_1100 : 32'h0;
            2:       return (n >= 2) ? 32'h0000_0020 : 32'h0;
            3:       return (n >= 3) ? 32'h0000_1120 : 32'h0;
            4:       return (n >= 4) ? 32'h0000_1164 : 32'h0;
            5:       return (n >= 5) ? 32'((n - 3) / 2) : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [7:0] font(logic [3:0] d);
        logic [7:0] tbl [16];
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return tbl[d];
    endfunction

    task automatic tick();
        @(posedge clk);
        if (sw[7]) n_exec = 0;
        else if (!btn[0]) n_exec++;
        #1;
    endtask

    task automatic exp_led(string nm, int sel);
        exp_t e;
        logic [31:0] v;
        sw[4:0] = sel[4:0];
        v = model_gpr(sel, n_exec);
        e.led = v[7:0];
        e.chk_disp = 1'b0;
        e.an = 4'hF;
        e.seg = 8'hFF;
        q.push_back(e);
        qn.push_back(nm);
    endtask

    task automatic exp_disp(string nm, int sel, int digit);
        exp_t e;
        logic [31:0] v;
        logic [3:0]  one;
        sw[4:0] = sel[4:0];
        v = model_gpr(sel, n_exec);
        one = 4'b0001;
        e.led = v[7:0];
        e.chk_disp = 1'b1;
        e.an = ~(one << digit);
        e.seg = font(v[digit*4 +: 4]);
        q.push_back(e);
        qn.push_back(nm);
    endtask

    always @(negedge clk) begin : monitor
        exp_t  e;
        string nm;
        while (q.size() > 0) begin
            e  = q.pop_front();
            nm = qn.pop_front();
            n_checks++;
            if (led === e.led) n_pass++;
            else $display("FAIL %s led: got %02h expected %02h (exec=%0d)", nm, led, e.led, n_exec);
            if (e.chk_disp) begin
                n_checks++;
                if (an === e.an && seg === e.seg) n_pass++;
                else $display("FAIL %s display: got an=%04b seg=%02h expected an=%04b seg=%02h",
                              nm, an, seg, e.an, e.seg);
            end
        end
    end

    initial begin
        sw  = 8'h83;
        btn = 5'h00;

        // Reset held; pause is asserted part way to show it is ignored.
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 5) btn[0] = 1'b1;
            exp_disp("reset", 3, 0);
        end
        btn[0] = 1'b0;
        sw[7]  = 1'b0;

        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i == 3) exp_disp("run_dig0", 3, 0);
            else exp_led(i == 4 ? "sel4" : "run3", i == 4 ? 4 : 3);
        end

        tick();
        force dut.r_refresh = 18'h10000;
        exp_disp("digit1", 3, 1);
        tick();
        force dut.r_refresh = 18'h20000;
        exp_disp("digit2", 3, 2);
        tick();
        force dut.r_refresh = 18'h30000;
        exp_disp("digit3", 3, 3);
        tick();
        force dut.r_refresh = 18'h00000;
        exp_disp("digit0", 3, 0);
        tick();
        release dut.r_refresh;
        exp_led("loop5_n9", 5);

        btn[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_led("pause", (i % 5 == 4) ? 0 : 5);
        end
        btn[0] = 1'b0;
        tick();
        exp_led("resume1", 5);
        tick();
        exp_led("resume2", 5);

        for (int i = 0; i < 40 && n_exec < 23; i++) begin
            tick();
            case (n_exec % 4)
                0: exp_led("loop_sel0", 0);
                1: exp_led("loop_sel6", 6);
                default: exp_led("loop_sel5", 5);
            endcase
        end
        exp_disp("loop_n23", 5, 0);

        sw[7]  = 1'b1;
        btn[0] = 1'b1;
        tick();
        sw[7]  = 1'b0;
        btn[0] = 1'b0;
        exp_disp("midrst", 5, 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp_led("restart", (i % 2 == 1) ? 5 : 3);
        end

        tick();
        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
